lc3_mem_sequencer: RTL and testbench

Multi-cycle memory access sequencer for the LC3 core. Accepts a single memory command (instruction fetch, load, store, indirect load, indirect store) from the control unit, drives MAR, MEM_WE and MEM_CLK toward the single-port memory, and captures read data into an internal MDR. Command completion is signalled by a one-cycle DONE pulse. It sits between the control unit's stage logic and the memory, replacing ad-hoc MAR_LE/MEM_WE/MEM_CLK decoding with a sequenced handshake.

---
 rtl/lc3_mem_pkg.sv | 34 +++
 rtl/lc3_mem_wait_timer.sv | 37 +++
 rtl/lc3_mem_sequencer.sv | 163 ++++++++++++++++
 tb/tb_lc3_mem_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - Shared command encodings, states and widths for the LC3 memory sequencer
// Feature macro: LC3_MEM_SEQ_INDIRECT_EN (accept LOAD_IND/STORE_IND)
package lc3_mem_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    CMD_FETCH     = 3'b000,
    CMD_LOAD      = 3'b001,
    CMD_STORE     = 3'b010,
    CMD_LOAD_IND  = 3'b011,
    CMD_STORE_IND = 3'b100
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_CAPTURE,
    S_FINISH,
    S_REJECT
  } state_e;

  // Indirect encodings only count as legal when the pointer path is built
  function automatic logic cmd_legal(input logic [2:0] c);
`ifdef LC3_MEM_SEQ_INDIRECT_EN
    return c <= 3'b100;
`else
    return c <= 3'b010;
`endif
  endfunction

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// rtl/lc3_mem_wait_timer.sv - Loadable wait-state down-counter with zero flag
module lc3_mem_wait_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);

  // A zero wait count never loads the timer, so clamp the unused load value
  localparam logic [3:0] LOAD_VAL = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [3:0] count_q, count_d;

  // Next count: reload on request, otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/lc3_mem_sequencer.sv
// rtl/lc3_mem_sequencer.sv - LC3 multi-cycle memory access sequencer
// Feature macro: LC3_MEM_SEQ_INDIRECT_EN builds the phase flag and pointer reload for *_IND
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        cmd,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mar,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_we,
  output logic              mem_clk
);

  state_e            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_clk_q, mem_clk_d;
  logic              mem_we_q, mem_we_d;
  logic              write_phase;
  logic              timer_load;
  logic              timer_zero;
`ifdef LC3_MEM_SEQ_INDIRECT_EN
  logic              phase_q, phase_d;
`endif

  lc3_mem_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .zero  (timer_zero)
  );

  // Next-state, datapath and registered-output decode for the access sequence
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    mar_d      = mar_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    timer_load = 1'b0;
`ifdef LC3_MEM_SEQ_INDIRECT_EN
    phase_d     = phase_q;
    // Indirect store reads the pointer first, then writes at it
    write_phase = (cmd_q == CMD_STORE) || ((cmd_q == CMD_STORE_IND) && phase_q);
`else
    write_phase = (cmd_q == CMD_STORE);
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (cmd_legal(cmd)) begin
            state_d   = S_SETUP;
            cmd_d     = cmd;
            mar_d     = addr;
            mem_din_d = wdata;
`ifdef LC3_MEM_SEQ_INDIRECT_EN
            phase_d   = 1'b0;
`endif
          end else begin
            state_d = S_REJECT;
          end
        end
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        if (WAIT_CYCLES > 0) begin
          state_d    = S_WAIT;
          timer_load = 1'b1;
        end else begin
          state_d = write_phase ? S_FINISH : S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (timer_zero) begin
          state_d = write_phase ? S_FINISH : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        rdata_d = mem_dout;
        state_d = S_FINISH;
`ifdef LC3_MEM_SEQ_INDIRECT_EN
        // First read of an indirect command fetched the pointer: re-run at it
        if (((cmd_q == CMD_LOAD_IND) || (cmd_q == CMD_STORE_IND)) && !phase_q) begin
          mar_d   = mem_dout;
          phase_d = 1'b1;
          state_d = S_SETUP;
        end
`endif
      end
      S_FINISH: state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    err_d     = (state_d == S_REJECT);
    mem_clk_d = (state_d == S_STROBE);
    mem_we_d  = (state_d == S_STROBE) && write_phase;
  end

  // Sequencer state and registered outputs; reset kills the strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= 3'b000;
      mar_q     <= '0;
      mem_din_q <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_clk_q <= 1'b0;
      mem_we_q  <= 1'b0;
`ifdef LC3_MEM_SEQ_INDIRECT_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      mar_q     <= mar_d;
      mem_din_q <= mem_din_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mem_clk_q <= mem_clk_d;
      mem_we_q  <= mem_we_d;
`ifdef LC3_MEM_SEQ_INDIRECT_EN
      phase_q   <= phase_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign mar     = mar_q;
  assign mem_din = mem_din_q;
  assign mem_clk = mem_clk_q;
  assign mem_we  = mem_we_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb/tb_lc3_mem_sequencer.sv - Self-checking bench: three sequencers (0/1/2 wait states) against a command-level model
module tb_lc3_mem_sequencer;

`ifdef LC3_MEM_SEQ_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic [2:0] cmd;
  logic [15:0] addr, wdata;
  logic [2:0] busy, done, err, mem_we, mem_clk;
  logic [2:0][15:0] rdata, mar, mem_din;

  logic [15:0] mem [3][65536];
  logic pre_we;
  logic [15:0] pre_addr, pre_data;

  logic [15:0] model_mem [65536];
  logic [15:0] model_rdata, model_mar, model_din;

  int cyc = 0;
  int strobe_cnt [3];
  int we_cnt [3];
  int done_cnt [3];
  int err_cnt [3];
  int done_cyc [3];
  logic [15:0] smar [3][8];
  int scyc [3][8];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [15:0] dout;
    assign dout = mem[gi][mar[gi]];
    lc3_mem_sequencer #(.WAIT_CYCLES(gi)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .cmd      (cmd),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .err      (err[gi]),
      .rdata    (rdata[gi]),
      .mar      (mar[gi]),
      .mem_din  (mem_din[gi]),
      .mem_dout (dout),
      .mem_we   (mem_we[gi]),
      .mem_clk  (mem_clk[gi])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memories: written on the strobe with write enable, or by bench preload
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_clk[i] && mem_we[i]) mem[i][mar[i]] <= mem_din[i];
      if (pre_we) mem[i][pre_addr] <= pre_data;
    end
  end

  // Event monitor sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_clk[i]) begin
        smar[i][3'(strobe_cnt[i])] <= mar[i];
        scyc[i][3'(strobe_cnt[i])] <= cyc;
        strobe_cnt[i] <= strobe_cnt[i] + 1;
      end
      if (mem_we[i]) we_cnt[i] <= we_cnt[i] + 1;
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
      if (err[i]) err_cnt[i] <= err_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    model_mem[a] = d;
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic check_reset(input string when);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_busy_w%0d", when, i), busy[i], 0);
      chk($sformatf("%s_done_w%0d", when, i), done[i], 0);
      chk($sformatf("%s_err_w%0d", when, i), err[i], 0);
      chk($sformatf("%s_memclk_w%0d", when, i), mem_clk[i], 0);
      chk($sformatf("%s_memwe_w%0d", when, i), mem_we[i], 0);
      chk($sformatf("%s_mar_w%0d", when, i), mar[i], 0);
      chk($sformatf("%s_memdin_w%0d", when, i), mem_din[i], 0);
      chk($sformatf("%s_rdata_w%0d", when, i), rdata[i], 0);
    end
  endtask

  // Issue one command (called mid-cycle with all sequencers idle) and check it against the model
  task automatic run_cmd(input logic [2:0] c, input logic [15:0] a, input logic [15:0] wd);
    int k, lat, n_str;
    bit legal, ind, wr;
    logic [15:0] p, tgt;
    int sc0 [3];
    int wc0 [3];
    int dc0 [3];
    int ec0 [3];
    legal = (c <= 3'd2) || (IND_EN && (c <= 3'd4));
    ind   = legal && ((c == 3'd3) || (c == 3'd4));
    wr    = legal && ((c == 3'd2) || (c == 3'd4));
    p     = model_mem[a];
    tgt   = ind ? p : a;
    n_str = ind ? 2 : (legal ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      sc0[i] = strobe_cnt[i];
      wc0[i] = we_cnt[i];
      dc0[i] = done_cnt[i];
      ec0[i] = err_cnt[i];
    end
    req = 1'b1; cmd = c; addr = a; wdata = wd; k = cyc;
    @(negedge clk); #1;
    req = 1'b0; addr = 16'($urandom); wdata = 16'($urandom);
    chk($sformatf("busy_k1_cmd%0d", c), busy, 3'b111);
    if (!legal) begin
      chk($sformatf("err_k1_cmd%0d", c), err, 3'b111);
      @(negedge clk); #1;
      chk($sformatf("busy_k2_cmd%0d", c), busy, 3'b000);
      chk($sformatf("err_k2_cmd%0d", c), err, 3'b000);
    end
    for (int t = 0; t < 40 && busy != 3'b000; t++) @(negedge clk);
    chk($sformatf("timeout_cmd%0d", c), busy, 3'b000);
    @(negedge clk); #1;

    if (legal) begin
      model_din = wd;
      model_mar = tgt;
      if (wr) model_mem[tgt] = wd;
      else model_rdata = model_mem[tgt];
      if (c == 3'd4) model_rdata = p;
    end

    for (int i = 0; i < 3; i++) begin
      case (c)
        3'd0, 3'd1: lat = 4 + i;
        3'd2:       lat = 3 + i;
        3'd3:       lat = 7 + 2 * i;
        default:    lat = 6 + 2 * i;
      endcase
      chk($sformatf("strobes_cmd%0d_w%0d", c, i), strobe_cnt[i] - sc0[i], n_str);
      chk($sformatf("wes_cmd%0d_w%0d", c, i), we_cnt[i] - wc0[i], wr ? 1 : 0);
      chk($sformatf("dones_cmd%0d_w%0d", c, i), done_cnt[i] - dc0[i], legal ? 1 : 0);
      chk($sformatf("errs_cmd%0d_w%0d", c, i), err_cnt[i] - ec0[i], legal ? 0 : 1);
      if (legal) begin
        chk($sformatf("done_cyc_cmd%0d_w%0d", c, i), done_cyc[i] - k, lat);
        chk($sformatf("strobe1_cyc_cmd%0d_w%0d", c, i), scyc[i][3'(sc0[i])] - k, 2);
        chk($sformatf("strobe1_mar_cmd%0d_w%0d", c, i), smar[i][3'(sc0[i])], a);
        if (ind) begin
          chk($sformatf("strobe2_cyc_cmd%0d_w%0d", c, i), scyc[i][3'(sc0[i] + 1)] - k, 5 + i);
          chk($sformatf("strobe2_mar_cmd%0d_w%0d", c, i), smar[i][3'(sc0[i] + 1)], p);
        end
      end
      if (wr) chk($sformatf("memwr_cmd%0d_w%0d", c, i), mem[i][tgt], wd);
      chk($sformatf("mar_cmd%0d_w%0d", c, i), mar[i], model_mar);
      chk($sformatf("rdata_cmd%0d_w%0d", c, i), rdata[i], model_rdata);
      chk($sformatf("memdin_cmd%0d_w%0d", c, i), mem_din[i], model_din);
    end
  endtask

  int k0;
  int sc_h [3];
  int dc_h [3];
  logic [15:0] pool [8];

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; cmd = 3'd0; addr = 16'd0; wdata = 16'd0;
    pre_we = 1'b0; pre_addr = 16'd0; pre_data = 16'd0;
    model_rdata = 16'd0; model_mar = 16'd0; model_din = 16'd0;
    @(negedge clk); #1;
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed: plain load, store, indirect load/store, illegal encodings
    poke(16'h3000, 16'hBEEF);
    run_cmd(3'd1, 16'h3000, 16'h5555);
    poke(16'h4001, 16'h0000);
    run_cmd(3'd2, 16'h4001, 16'h1234);
    poke(16'h3010, 16'h5000);
    poke(16'h5000, 16'h00AA);
    run_cmd(3'd3, 16'h3010, 16'h0000);
    poke(16'h3020, 16'h5100);
    poke(16'h5100, 16'h0000);
    run_cmd(3'd4, 16'h3020, 16'h7777);
    run_cmd(3'd5, 16'h1111, 16'h2222);
    run_cmd(3'd7, 16'h3333, 16'h4444);

    // Reset asserted mid-strobe of a store: strobe drops at once, nothing written
    poke(16'h6000, 16'h1111);
    for (int i = 0; i < 3; i++) dc_h[i] = done_cnt[i];
    req = 1'b1; cmd = 3'd2; addr = 16'h6000; wdata = 16'h2222;
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_memclk", mem_clk, 3'b111);
    chk("rst_pre_memwe", mem_we, 3'b111);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    model_rdata = 16'd0; model_mar = 16'd0; model_din = 16'd0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_nowrite_w%0d", i), mem[i][16'h6000], 16'h1111);
      chk($sformatf("rst_nodone_w%0d", i), done_cnt[i] - dc_h[i], 0);
    end

    // REQ held high through a FETCH while ADDR changes
    poke(16'h2000, 16'hA1A1);
    poke(16'h2100, 16'hB2B2);
    for (int i = 0; i < 3; i++) begin
      sc_h[i] = strobe_cnt[i];
      dc_h[i] = done_cnt[i];
    end
    req = 1'b1; cmd = 3'd0; addr = 16'h2000; wdata = 16'h0F0F; k0 = cyc;
    @(negedge clk); #1;
    addr = 16'h2100;
    while (cyc < k0 + 8) @(negedge clk);
    #1;
    req = 1'b0;
    for (int t = 0; t < 40 && busy != 3'b000; t++) @(negedge clk);
    chk("held_timeout", busy, 3'b000);
    @(negedge clk); #1;
    model_rdata = model_mem[16'h2100]; model_mar = 16'h2100; model_din = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_strobes_w%0d", i), strobe_cnt[i] - sc_h[i], 2);
      chk($sformatf("held_dones_w%0d", i), done_cnt[i] - dc_h[i], 2);
      chk($sformatf("held_mar1_w%0d", i), smar[i][3'(sc_h[i])], 16'h2000);
      chk($sformatf("held_cyc1_w%0d", i), scyc[i][3'(sc_h[i])] - k0, 2);
      chk($sformatf("held_mar2_w%0d", i), smar[i][3'(sc_h[i] + 1)], 16'h2100);
      chk($sformatf("held_after_done_w%0d", i), scyc[i][3'(sc_h[i] + 1)] - k0 > 4 + i, 1);
      chk($sformatf("held_rdata_w%0d", i), rdata[i], model_rdata);
      chk($sformatf("held_mar_w%0d", i), mar[i], model_mar);
    end

    // Randomized commands over a closed pool of pointer-valued locations
    for (int j = 0; j < 8; j++) pool[j] = 16'($urandom);
    for (int j = 0; j < 8; j++) poke(pool[j], pool[(j + 1) % 8]);
    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(0, 7)), pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
